// File: rtl/allgates_checker.sv
// Self-test sequencer/checker for the all-gates cell set: walks 16 vectors, compares 13 outputs.
// Optional: define ALLGATES_CHK_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module allgates_checker #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             d_o,
    input  logic [12:0]      dut_o,
    output logic [12:0]      fail_mask,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);

    state_t           state_q;
    logic [3:0]       vec_q;
    logic [3:0]       set_q;
    logic [12:0]      fail_q;
    logic [12:0]      fail_d;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic [3:0]       ffv_q;
    logic             ffvalid_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic        a, b, c, d;
    logic [12:0] golden;
    logic [12:0] mism;
    logic        any_mis;
    logic        sample;
    logic        finish;

    assign a = vec_q[0];
    assign b = vec_q[1];
    assign c = vec_q[2];
    assign d = vec_q[3];

    // Reference model is driven by the same registered vector the gate block sees
    always_comb begin
        golden      = '0;
        golden[0]   = ~a;
        golden[1]   = a & b;
        golden[2]   = ~(a & b);
        golden[3]   = a & ~b;
        golden[4]   = a | b;
        golden[5]   = ~(a | b);
        golden[6]   = a | ~b;
        golden[7]   = a ^ b;
        golden[8]   = ~(a ^ b);
        golden[9]   = ~((a & b) | c);
        golden[10]  = ~((a | b) & c);
        golden[11]  = ~((a & b) | (c & d));
        golden[12]  = ~((a | b) & (c | d));
    end

    assign mism    = dut_o ^ golden;
    assign any_mis = |mism;
    assign sample  = (state_q == APPLY) && (set_q == SET_LAST);
    assign fail_d  = fail_q | mism;
    assign err_d   = (err_q == '1) ? err_q : err_q + 1'b1;

`ifdef ALLGATES_CHK_STOP_ON_FAIL_EN
    assign finish = any_mis || (vec_q == 4'hF);
`else
    assign finish = (vec_q == 4'hF);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            set_q     <= '0;
            fail_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= APPLY;
                        vec_q     <= '0;
                        set_q     <= '0;
                        fail_q    <= '0;
                        err_q     <= '0;
                        ffv_q     <= '0;
                        ffvalid_q <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                APPLY: begin
                    if (sample) begin
                        fail_q <= fail_d;
                        if (any_mis) begin
                            err_q <= err_d;
                            if (!ffvalid_q) begin
                                ffv_q     <= vec_q;
                                ffvalid_q <= 1'b1;
                            end
                        end
                        if (finish) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (fail_d == '0);
                        end else begin
                            vec_q <= vec_q + 4'd1;
                            set_q <= '0;
                        end
                    end else begin
                        set_q <= set_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign a_o              = vec_q[0];
    assign b_o              = vec_q[1];
    assign c_o              = vec_q[2];
    assign d_o              = vec_q[3];
    assign fail_mask        = fail_q;
    assign err_cnt          = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_allgates_checker.sv
// Directed bench for allgates_checker: SETTLE=1 and SETTLE=3 instances,
// injected gate faults, restart/reset mid-run and off-sample glitches.
module tb_allgates_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start3;
    logic [1:0] fault;
    logic       glitch3;

    logic        busy1, done1, pass1, a1, b1, c1, d1, fvv1;
    logic [12:0] dut1, fm1;
    logic [4:0]  ec1;
    logic [3:0]  fv1;

    logic        busy3, done3, pass3, a3, b3, c3, d3, fvv3;
    logic [12:0] dut3, fm3;
    logic [4:0]  ec3;
    logic [3:0]  fv3;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural gate block with optional faults: 1 = xor stuck 0, 2 = nand inverted
    function automatic logic [12:0] gates(input logic [3:0] v, input logic [1:0] f);
        logic [12:0] g;
        logic a, b, c, d;
        a = v[0]; b = v[1]; c = v[2]; d = v[3];
        g[0]  = !a;
        g[1]  = a && b;
        g[2]  = !(a && b);
        g[3]  = a && !b;
        g[4]  = a || b;
        g[5]  = !(a || b);
        g[6]  = a || !b;
        g[7]  = a != b;
        g[8]  = a == b;
        g[9]  = !((a && b) || c);
        g[10] = !((a || b) && c);
        g[11] = !((a && b) || (c && d));
        g[12] = !((a || b) && (c || d));
        if (f == 2'd1) g[7] = 1'b0;
        if (f == 2'd2) g[2] = !g[2];
        return g;
    endfunction

    assign dut1 = gates({d1, c1, b1, a1}, fault);
    assign dut3 = glitch3 ? ~gates({d3, c3, b3, a3}, 2'd0)
                          : gates({d3, c3, b3, a3}, 2'd0);

    allgates_checker #(.SETTLE(1), .CNT_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .busy(busy1), .done(done1), .pass(pass1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
        .dut_o(dut1), .fail_mask(fm1), .err_cnt(ec1),
        .first_fail_vec(fv1), .first_fail_valid(fvv1)
    );

    allgates_checker #(.SETTLE(3), .CNT_W(5)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .busy(busy3), .done(done3), .pass(pass3),
        .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3),
        .dut_o(dut3), .fail_mask(fm3), .err_cnt(ec3),
        .first_fail_vec(fv3), .first_fail_valid(fvv3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on u1 and wait for done; returns cycles after acceptance and busy cycles
    task automatic run1(output int cyc, output int bcnt);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc  = 0;
        bcnt = 0;
        while (!done1 && cyc < 200) begin
            if (busy1) bcnt++;
            tick();
            cyc++;
        end
        if (cyc >= 200) chk("timeout1", 32'(done1), 32'd1);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_busy"}, 32'(busy1), 0);
        chk({tag, "_done"}, 32'(done1), 0);
        chk({tag, "_pass"}, 32'(pass1), 0);
        chk({tag, "_abcd"}, 32'({d1, c1, b1, a1}), 0);
        chk({tag, "_fm"},   32'(fm1), 0);
        chk({tag, "_ec"},   32'(ec1), 0);
        chk({tag, "_fv"},   32'(fv1), 0);
        chk({tag, "_fvv"},  32'(fvv1), 0);
    endtask

    int cyc, bcnt;

    initial begin
        rst_n   = 1'b0;
        start1  = 1'b0;
        start3  = 1'b0;
        fault   = 2'd0;
        glitch3 = 1'b0;
        tick();
        tick();
        chk_zero1("rst");
        chk("rst3_abcd", 32'({d3, c3, b3, a3}), 0);
        chk("rst3_done", 32'(done3), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy1), 0);

        // clean run
        run1(cyc, bcnt);
        chk("ok_lat",  cyc, 16);
        chk("ok_busy", bcnt, 16);
        chk("ok_done", 32'(done1), 1);
        chk("ok_pass", 32'(pass1), 1);
        chk("ok_fm",   32'(fm1), 0);
        chk("ok_ec",   32'(ec1), 0);
        chk("ok_fvv",  32'(fvv1), 0);
        chk("ok_abcd", 32'({d1, c1, b1, a1}), 32'hF);
        tick();
        chk("ok_hold", 32'(done1), 1);

        // xor stuck at 0: mismatches on vectors 1,2,5,6,9,10,13,14
        fault = 2'd1;
        run1(cyc, bcnt);
        chk("xor_fm",   32'(fm1), 32'h0080);
        chk("xor_fv",   32'(fv1), 1);
        chk("xor_fvv",  32'(fvv1), 1);
        chk("xor_pass", 32'(pass1), 0);
`ifdef ALLGATES_CHK_STOP_ON_FAIL_EN
        chk("xor_lat",  cyc, 2);
        chk("xor_ec",   32'(ec1), 1);
        chk("xor_abcd", 32'({d1, c1, b1, a1}), 32'h1);
`else
        chk("xor_lat",  cyc, 16);
        chk("xor_ec",   32'(ec1), 8);
        chk("xor_abcd", 32'({d1, c1, b1, a1}), 32'hF);
`endif

        // nand inverted: every vector mismatches
        fault = 2'd2;
        run1(cyc, bcnt);
        chk("nand_fm",   32'(fm1), 32'h0004);
        chk("nand_fv",   32'(fv1), 0);
        chk("nand_pass", 32'(pass1), 0);
`ifdef ALLGATES_CHK_STOP_ON_FAIL_EN
        chk("nand_lat", cyc, 1);
        chk("nand_ec",  32'(ec1), 1);
`else
        chk("nand_lat", cyc, 16);
        chk("nand_ec",  32'(ec1), 16);
`endif

        // SETTLE=3 with dut_o inverted except in the cycle before each sample edge
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 200) begin
            glitch3 = (cyc % 3 != 2);
            if (cyc < 48) chk("s3_vec", 32'({d3, c3, b3, a3}), 32'(cyc / 3));
            tick();
            cyc++;
        end
        glitch3 = 1'b0;
        chk("s3_lat",  cyc, 48);
        chk("s3_pass", 32'(pass3), 1);
        chk("s3_fm",   32'(fm3), 0);
        chk("s3_ec",   32'(ec3), 0);

        // start re-pulsed mid-run is ignored
        fault = 2'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (5) tick();
        cyc = 5;
        chk("rs_vec5", 32'({d1, c1, b1, a1}), 5);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc++;
        chk("rs_vec6", 32'({d1, c1, b1, a1}), 6);
        while (!done1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rs_lat",  cyc, 16);
        chk("rs_pass", 32'(pass1), 1);

        // reset mid-run aborts immediately
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (5) tick();
        chk("mr_vec5", 32'({d1, c1, b1, a1}), 5);
        rst_n = 1'b0;
        tick();
        chk_zero1("mr");
        rst_n = 1'b1;
        tick();
        chk("mr_idle", 32'(busy1), 0);
        run1(cyc, bcnt);
        chk("mr_lat",  cyc, 16);
        chk("mr_pass", 32'(pass1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
